gpif_frame_unpacker: RTL and testbench
======================================

Name: gpif_frame_unpacker

Overview:
- Receive-side counterpart of the ADC capture framer: accepts 32-bit GPIF2 frames, each carrying two 10-bit ADC samples tagged with 6-bit tic counts.
- Buffers frames in a small FIFO, serialises them back into a per-sample valid/ready stream, and checks tic-count continuity.
- Sits on the loopback/test path between the frame bus and downstream DSP or scoreboard logic.

Parameters:
- FIFO_DEPTH, 4, frame FIFO depth in frames; power of two, minimum 2.
- SAMPLE_W, 10, ADC sample width in bits.
- TIC_W, 6, tic counter width in bits; SAMPLE_W + TIC_W = 16.
- ERR_CNT_W, 16, width of the saturating sequence-error counter.

Ports:
- c0_sig  input  1  clock, rising-edge.
- areset_sig  input  1  reset, synchronous, active-high.
- frame_in  input  32  frame word, laid out as {tic_hi, sample_hi, tic_lo, sample_lo}.
- frame_valid  input  1  frame qualifier; each high cycle delivers one frame; no backpressure.
- sample_out  output  SAMPLE_W  unpacked sample.
- tic_out  output  TIC_W  tic count of sample_out.
- sample_valid  output  1  sample_out/tic_out valid.
- sample_ready  input  1  downstream accept.
- seq_err_cnt  output  ERR_CNT_W  saturating count of continuity errors.
- overflow  output  1  sticky flag: a frame was dropped on a full FIFO.
- err_clear  input  1  clears seq_err_cnt and overflow.

Behaviour:
- Reset (areset_sig=1 at a rising edge):
  - FIFO emptied; FSM goes to IDLE.
  - sample_valid=0, sample_out=0, tic_out=0, seq_err_cnt=0, overflow=0, resync=1.
- Frame layout:
  - sample_lo = [9:0] and tic_lo = [15:10] form the earlier sample.
  - sample_hi = [25:16] and tic_hi = [31:26] form the later sample.
- Push side:
  - frame_valid=1 with FIFO not full: write the frame at that edge.
  - FIFO full: the frame is dropped, overflow is set, and resync is set.
  - Full FIFO with a pop in the same cycle: the write is accepted.
- Continuity check, evaluated on accepted writes only, with all arithmetic modulo 2^TIC_W:
  - Intra-frame: tic_hi must equal tic_lo+1.
  - Inter-frame: tic_lo must equal last_tic_hi+1. The inter-frame check is skipped when resync=1.
  - Each failing check increments seq_err_cnt by 1 (a frame failing both checks adds 2), saturating at all-ones.
  - After any accepted write: last_tic_hi <= tic_hi and resync <= 0.
  - Wrap is legal: tic 63 followed by 0 is not an error.
- err_clear:
  - Zeroes seq_err_cnt and overflow at that edge.
  - Has priority over increments and drops in the same cycle.
- Output FSM states: IDLE, EMIT_LO, EMIT_HI.
  - IDLE: when the FIFO is non-empty, load sample_lo/tic_lo from the FIFO head and go to EMIT_LO with sample_valid=1.
  - EMIT_LO: hold outputs until sample_valid & sample_ready; then load sample_hi/tic_hi and go to EMIT_HI.
  - EMIT_HI: on handshake, pop the FIFO head. If another frame is available (counting the head left after the pop), load its lo half and go to EMIT_LO; otherwise clear sample_valid and go to IDLE.
- Output handshake:
  - Outputs are registered and stable while sample_valid=1 and sample_ready=0.
  - Sustained throughput is 1 sample/cycle with sample_ready held at 1.
- Latency:
  - frame_valid in cycle N with the FIFO empty and the FSM in IDLE gives sample_valid=1 with the lo sample in cycle N+2.
  - The hi sample follows in cycle N+3 if sample_ready=1.
- Reset mid-operation: the in-flight frame and all buffered frames are discarded; no partial sample is emitted afterwards.

Decomposition:
- Shared package gpif_frame_pkg holds:
  - the FRAME_W=32, SAMPLE_W and TIC_W constants;
  - the field bit-offset localparams;
  - a packed frame typedef {tic_hi, sample_hi, tic_lo, sample_lo}, also intended for the capture framer.
- One sub-module, gpif_frame_fifo:
  - synchronous single-clock FIFO, FIFO_DEPTH x 32;
  - full/empty flags, pointer wrap via an extra MSB;
  - same c0_sig/areset_sig reset semantics.

Test Plan:
- Single frame 0x0C05_0801 (tic_hi=3, sample_hi=5, tic_lo=2, sample_lo=1) with sample_ready=1 -> lo sample (1, tic 2) in cycle N+2, then hi sample (5, tic 3) in N+3; seq_err_cnt=0.
- Back-to-back frames with tics 0..63 then a wrap to 0, sample_ready=1 -> 128+ samples in order at 1/cycle, tics 62,63,0,1 across the wrap; seq_err_cnt=0.
- Frame with tic_lo=10, tic_hi=12 following a frame with tic_hi=9 -> seq_err_cnt=1 (intra-frame only); samples still emitted.
- sample_ready=0 while FIFO_DEPTH+1 frames are pushed -> the last frame is dropped and overflow=1. The next accepted frame has a deliberately discontinuous tic_lo and adds no inter-frame error (resync). Outputs hold stable throughout.
- err_clear pulsed with seq_err_cnt=5 and overflow=1 -> both read 0 the next cycle. Saturation: force 2^16 errors -> seq_err_cnt holds 0xFFFF.
- areset_sig asserted while in EMIT_LO with 3 frames buffered -> next cycle sample_valid=0 and the FIFO is empty; a fresh frame afterwards follows the N+2 latency.

Source files
------------

// File: rtl/gpif_frame_pkg.sv
// Shared definitions for the GPIF2 ADC frame format, used by the capture
// framer and the receive-side unpacker.
//   FRAME_W / SAMPLE_W / TIC_W : frame and field widths
//   *_OFF                      : field bit offsets inside a frame word
//   frame_t                    : packed frame {tic_hi, sample_hi, tic_lo, sample_lo}
//   emit_state_t               : unpacker output FSM states
package gpif_frame_pkg;

  localparam int unsigned FRAME_W  = 32;
  localparam int unsigned SAMPLE_W = 10;
  localparam int unsigned TIC_W    = 6;
  localparam int unsigned HALF_W   = SAMPLE_W + TIC_W;

  localparam int unsigned SAMPLE_LO_OFF = 0;
  localparam int unsigned TIC_LO_OFF    = SAMPLE_W;
  localparam int unsigned SAMPLE_HI_OFF = HALF_W;
  localparam int unsigned TIC_HI_OFF    = HALF_W + SAMPLE_W;

  typedef struct packed {
    logic [TIC_W-1:0]    tic_hi;
    logic [SAMPLE_W-1:0] sample_hi;
    logic [TIC_W-1:0]    tic_lo;
    logic [SAMPLE_W-1:0] sample_lo;
  } frame_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EMIT_LO,
    ST_EMIT_HI
  } emit_state_t;

endpackage

// File: rtl/gpif_frame_unpacker_if.sv
// Frame-in / sample-out bus of the GPIF frame unpacker.
//   frame_in, frame_valid          : frame push (no backpressure)
//   sample_out, tic_out,
//   sample_valid, sample_ready     : per-sample valid/ready stream
// master = source of frames and sink of samples; slave = the unpacker.
interface gpif_frame_unpacker_if
  import gpif_frame_pkg::*;
#(
  parameter int unsigned SAMPLE_W = 10,
  parameter int unsigned TIC_W    = 6
) ();

  logic [FRAME_W-1:0]  frame_in;
  logic                frame_valid;
  logic [SAMPLE_W-1:0] sample_out;
  logic [TIC_W-1:0]    tic_out;
  logic                sample_valid;
  logic                sample_ready;

  modport master (
    output frame_in, frame_valid, sample_ready,
    input  sample_out, tic_out, sample_valid
  );

  modport slave (
    input  frame_in, frame_valid, sample_ready,
    output sample_out, tic_out, sample_valid
  );

endinterface

// File: rtl/gpif_frame_fifo.sv
// Single-clock frame FIFO with extra-MSB pointer wrap.
//   c0_sig, areset_sig : clock, synchronous active-high reset (empties FIFO)
//   wr_en, din         : write port (caller guarantees not full unless rd_en)
//   rd_en              : pop head
//   dout, dout_next    : head entry and the entry behind it
//   full, empty, multi : status; multi = at least two entries held
module gpif_frame_fifo #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned WIDTH      = 32
) (
  input  logic             c0_sig,
  input  logic             areset_sig,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] dout_next,
  output logic             full,
  output logic             empty,
  output logic             multi
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      count;
  logic [AW-1:0]    rd_next_idx;

  assign count       = wr_ptr - rd_ptr;
  assign empty       = (wr_ptr == rd_ptr);
  assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign multi       = (count > (AW+1)'(1));
  assign rd_next_idx = rd_ptr[AW-1:0] + AW'(1);
  assign dout        = mem[rd_ptr[AW-1:0]];
  assign dout_next   = mem[rd_next_idx];

  always_ff @(posedge c0_sig) begin
    if (areset_sig) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge c0_sig) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/gpif_frame_unpacker.sv
// Receive-side GPIF2 frame unpacker: buffers 32-bit frames, emits the two
// samples of each frame as a valid/ready stream (lo first), and checks
// tic-count continuity on every accepted frame.
//   c0_sig, areset_sig : clock, synchronous active-high reset
//   bus (slave)        : frame_in/frame_valid in, sample_out/tic_out/
//                        sample_valid out, sample_ready in
//   seq_err_cnt        : saturating continuity-error count
//   overflow           : sticky, a frame was dropped on a full FIFO
//   err_clear          : clears seq_err_cnt and overflow (wins over updates)
module gpif_frame_unpacker #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned SAMPLE_W   = gpif_frame_pkg::SAMPLE_W,
  parameter int unsigned TIC_W      = gpif_frame_pkg::TIC_W,
  parameter int unsigned ERR_CNT_W  = 16
) (
  input  logic                  c0_sig,
  input  logic                  areset_sig,
  gpif_frame_unpacker_if.slave  bus,
  output logic [ERR_CNT_W-1:0]  seq_err_cnt,
  output logic                  overflow,
  input  logic                  err_clear
);

  import gpif_frame_pkg::*;

  logic               fifo_full, fifo_empty, fifo_multi;
  logic               wr_en, pop, drop, fire;
  logic [FRAME_W-1:0] head_w, next_w;
  frame_t             head, next_fr;

  emit_state_t         state, state_n;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic [TIC_W-1:0]    tic_q, tic_d;
  logic                valid_q, valid_d;

  logic [TIC_W-1:0]    in_tic_lo, in_tic_hi, last_tic_hi;
  logic                resync, intra_err, inter_err;
  logic [ERR_CNT_W:0]  err_sum;

  assign head    = frame_t'(head_w);
  assign next_fr = frame_t'(next_w);

  // A full FIFO still accepts a frame when the head is popped in the same cycle.
  assign wr_en = bus.frame_valid & (~fifo_full | pop);
  assign drop  = bus.frame_valid & fifo_full & ~pop;
  assign fire  = valid_q & bus.sample_ready;

  gpif_frame_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (FRAME_W)
  ) u_fifo (
    .c0_sig     (c0_sig),
    .areset_sig (areset_sig),
    .wr_en      (wr_en),
    .din        (bus.frame_in),
    .rd_en      (pop),
    .dout       (head_w),
    .dout_next  (next_w),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .multi      (fifo_multi)
  );

  // State and registered outputs.
  always_ff @(posedge c0_sig) begin
    if (areset_sig) begin
      state    <= ST_IDLE;
      sample_q <= '0;
      tic_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      state    <= state_n;
      sample_q <= sample_d;
      tic_q    <= tic_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:    if (!fifo_empty) state_n = ST_EMIT_LO;
      ST_EMIT_LO: if (fire)        state_n = ST_EMIT_HI;
      ST_EMIT_HI: if (fire)        state_n = fifo_multi ? ST_EMIT_LO : ST_IDLE;
      default:                     state_n = ST_IDLE;
    endcase
  end

  // Leaving EMIT_HI pops the head, so the follow-on lo half comes from the
  // entry behind it rather than from the (still unpopped) head.
  always_comb begin
    sample_d = sample_q;
    tic_d    = tic_q;
    valid_d  = valid_q;
    pop      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          sample_d = head.sample_lo;
          tic_d    = head.tic_lo;
          valid_d  = 1'b1;
        end
      end
      ST_EMIT_LO: begin
        if (fire) begin
          sample_d = head.sample_hi;
          tic_d    = head.tic_hi;
        end
      end
      ST_EMIT_HI: begin
        if (fire) begin
          pop = 1'b1;
          if (fifo_multi) begin
            sample_d = next_fr.sample_lo;
            tic_d    = next_fr.tic_lo;
            valid_d  = 1'b1;
          end else begin
            valid_d  = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  assign bus.sample_out   = sample_q;
  assign bus.tic_out      = tic_q;
  assign bus.sample_valid = valid_q;

  // Continuity checking on accepted writes.
  assign in_tic_lo = bus.frame_in[TIC_LO_OFF +: TIC_W];
  assign in_tic_hi = bus.frame_in[TIC_HI_OFF +: TIC_W];
  assign intra_err = (in_tic_hi != in_tic_lo + TIC_W'(1));
  assign inter_err = ~resync & (in_tic_lo != last_tic_hi + TIC_W'(1));
  assign err_sum   = {1'b0, seq_err_cnt} + (ERR_CNT_W+1)'(intra_err)
                                         + (ERR_CNT_W+1)'(inter_err);

  always_ff @(posedge c0_sig) begin
    if (areset_sig) begin
      seq_err_cnt <= '0;
      overflow    <= 1'b0;
      resync      <= 1'b1;
      last_tic_hi <= '0;
    end else begin
      if (err_clear) begin
        seq_err_cnt <= '0;
        overflow    <= 1'b0;
      end else begin
        if (wr_en) seq_err_cnt <= err_sum[ERR_CNT_W] ? '1 : err_sum[ERR_CNT_W-1:0];
        if (drop)  overflow    <= 1'b1;
      end
      if (wr_en) begin
        last_tic_hi <= in_tic_hi;
        resync      <= 1'b0;
      end else if (drop) begin
        resync      <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gpif_frame_unpacker.sv
module tb_gpif_frame_unpacker;
  import gpif_frame_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        err_clear;
  logic [15:0] seq_err_cnt;
  logic        overflow;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned cyc      = 0;
  int unsigned hs_n, hs_first, hs_last;
  bit          mon_en = 1'b0;
  bit          prev_v, prev_r;
  logic [9:0]  prev_s;
  logic [5:0]  prev_t;
  logic [15:0] exp_q [$];

  gpif_frame_unpacker_if #(.SAMPLE_W(10), .TIC_W(6)) bus ();

  gpif_frame_unpacker #(
    .FIFO_DEPTH (4),
    .SAMPLE_W   (10),
    .TIC_W      (6),
    .ERR_CNT_W  (16)
  ) u_dut (
    .c0_sig      (clk),
    .areset_sig  (rst),
    .bus         (bus),
    .seq_err_cnt (seq_err_cnt),
    .overflow    (overflow),
    .err_clear   (err_clear)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] mk_frame(input logic [5:0] th, input logic [9:0] sh,
                                           input logic [5:0] tl, input logic [9:0] sl);
    logic [31:0] f;
    f = '0;
    f[TIC_HI_OFF +: TIC_W]       = th;
    f[SAMPLE_HI_OFF +: SAMPLE_W] = sh;
    f[TIC_LO_OFF +: TIC_W]       = tl;
    f[SAMPLE_LO_OFF +: SAMPLE_W] = sl;
    return f;
  endfunction

  task automatic send(input logic [31:0] f, input bit expect_out);
    @(posedge clk); #1;
    bus.frame_in    = f;
    bus.frame_valid = 1'b1;
    if (expect_out) begin
      exp_q.push_back({f[9:0], f[15:10]});
      exp_q.push_back({f[25:16], f[31:26]});
    end
  endtask

  task automatic gap();
    @(posedge clk); #1;
    bus.frame_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain", exp_q.size(), 0);
  endtask

  // Scoreboard and hold-stability monitor, sampled away from the active edge.
  always @(negedge clk) begin
    logic [15:0] e;
    if (mon_en) begin
      if (prev_v && !prev_r) begin
        check("hold_valid",  bus.sample_valid, 1);
        check("hold_sample", bus.sample_out, prev_s);
        check("hold_tic",    bus.tic_out, prev_t);
      end
      if (bus.sample_valid && bus.sample_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected", bus.sample_out, 10'h3ff);
        end else begin
          e = exp_q.pop_front();
          check("sb_sample", bus.sample_out, e[15:6]);
          check("sb_tic",    bus.tic_out, e[5:0]);
        end
        if (hs_n == 0) hs_first = cyc;
        hs_last = cyc;
        hs_n++;
      end
      prev_v = bus.sample_valid;
      prev_r = bus.sample_ready;
      prev_s = bus.sample_out;
      prev_t = bus.tic_out;
    end else begin
      prev_v = 1'b0;
    end
  end

  initial begin
    #5_000_000;
    n_checks++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    logic [31:0] f;
    rst = 1'b1; err_clear = 1'b0;
    bus.frame_in = '0; bus.frame_valid = 1'b0; bus.sample_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid",  bus.sample_valid, 0);
    check("rst_sample", bus.sample_out, 0);
    check("rst_tic",    bus.tic_out, 0);
    check("rst_err",    seq_err_cnt, 0);
    check("rst_ovf",    overflow, 0);
    rst = 1'b0;

    // Single frame latency: lo in N+2, hi in N+3.
    send(32'h0C05_0801, 1'b0);
    gap();
    check("t1_n1_valid", bus.sample_valid, 0);
    @(posedge clk); #1;
    check("t1_lo_valid",  bus.sample_valid, 1);
    check("t1_lo_sample", bus.sample_out, 1);
    check("t1_lo_tic",    bus.tic_out, 2);
    @(posedge clk); #1;
    check("t1_hi_valid",  bus.sample_valid, 1);
    check("t1_hi_sample", bus.sample_out, 5);
    check("t1_hi_tic",    bus.tic_out, 3);
    @(posedge clk); #1;
    check("t1_done_valid", bus.sample_valid, 0);
    check("t1_err", seq_err_cnt, 0);

    // Continuous stream across the tic wrap, one frame per two cycles.
    mon_en = 1'b1;
    hs_n = 0;
    for (int k = 0; k < 66; k++) begin
      send(mk_frame(6'((4 + 2*k + 1) % 64), 10'($urandom), 6'((4 + 2*k) % 64), 10'($urandom)), 1'b1);
      gap();
    end
    wait_drain();
    check("t2_count", hs_n, 132);
    check("t2_rate",  hs_last - hs_first + 1, hs_n);
    check("t2_err",   seq_err_cnt, 0);
    check("t2_ovf",   overflow, 0);

    // Intra-frame error only.
    send(mk_frame(6'd9, 10'h111, 6'd8, 10'h110), 1'b1);
    gap();
    send(mk_frame(6'd12, 10'h222, 6'd10, 10'h221), 1'b1);
    gap();
    wait_drain();
    check("t3_err", seq_err_cnt, 1);

    // Overflow with a stalled sink, then resync on a discontinuous frame.
    @(posedge clk); #1;
    bus.sample_ready = 1'b0;
    for (int k = 0; k < 5; k++)
      send(mk_frame(6'(14 + 2*k), 10'($urandom), 6'(13 + 2*k), 10'($urandom)), k < 4);
    gap();
    repeat (5) @(posedge clk);
    #1;
    check("t4_ovf",   overflow, 1);
    check("t4_valid", bus.sample_valid, 1);
    bus.sample_ready = 1'b1;
    wait_drain();
    send(mk_frame(6'd41, 10'h3aa, 6'd40, 10'h355), 1'b1);
    gap();
    wait_drain();
    check("t4_resync_err", seq_err_cnt, 1);

    // Double-failing frames, then err_clear and its priority.
    send(mk_frame(6'd5, 10'h001, 6'd0, 10'h002), 1'b1);
    gap();
    send(mk_frame(6'd7, 10'h003, 6'd0, 10'h004), 1'b1);
    gap();
    wait_drain();
    check("t5_err5", seq_err_cnt, 5);
    check("t5_ovf1", overflow, 1);
    @(posedge clk); #1; err_clear = 1'b1;
    @(posedge clk); #1; err_clear = 1'b0;
    check("t5_clr_err", seq_err_cnt, 0);
    check("t5_clr_ovf", overflow, 0);
    f = mk_frame(6'd5, 10'h005, 6'd0, 10'h006);
    send(f, 1'b1);
    err_clear = 1'b1;
    gap();
    err_clear = 1'b0;
    check("t5_clr_prio", seq_err_cnt, 0);
    wait_drain();

    // Saturation: every frame adds two errors.
    mon_en = 1'b0;
    for (int k = 0; k < 32767; k++) begin
      send(f, 1'b0);
      gap();
    end
    repeat (4) @(posedge clk);
    #1;
    check("sat_fffe", seq_err_cnt, 16'hfffe);
    send(f, 1'b0); gap();
    check("sat_ffff", seq_err_cnt, 16'hffff);
    send(f, 1'b0); gap();
    check("sat_hold", seq_err_cnt, 16'hffff);
    check("sat_ovf",  overflow, 0);
    repeat (6) @(posedge clk);

    // Reset while emitting with three frames buffered.
    #1;
    bus.sample_ready = 1'b0;
    for (int k = 0; k < 3; k++) send(mk_frame(6'(k), 10'(k), 6'(k), 10'(k)), 1'b0);
    gap();
    check("t6_pre_valid", bus.sample_valid, 1);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;
    check("t6_rst_valid",  bus.sample_valid, 0);
    check("t6_rst_sample", bus.sample_out, 0);
    check("t6_rst_err",    seq_err_cnt, 0);
    rst = 1'b0;
    bus.sample_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("t6_empty_valid", bus.sample_valid, 0);
    end
    f = mk_frame(6'd22, 10'h234, 6'd21, 10'h278);
    send(f, 1'b0);
    gap();
    check("t6_n1_valid", bus.sample_valid, 0);
    @(posedge clk); #1;
    check("t6_lo_valid",  bus.sample_valid, 1);
    check("t6_lo_sample", bus.sample_out, 10'h278);
    check("t6_lo_tic",    bus.tic_out, 21);
    @(posedge clk); #1;
    check("t6_hi_sample", bus.sample_out, 10'h234);
    check("t6_hi_tic",    bus.tic_out, 22);
    @(posedge clk); #1;
    check("t6_done_valid", bus.sample_valid, 0);
    check("t6_err", seq_err_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
